// File: rtl/kiwi_run_pkg.sv
// Shared types and defaults for the KiwiC run monitor: controller states,
// the 2-bit host status code, and default hold/watchdog lengths.
package kiwi_run_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HOLD,
        RUN,
        DONE,
        TIMEOUT,
        ERROR
    } run_state_e;

    typedef enum logic [1:0] {
        STATUS_NONE    = 2'd0,
        STATUS_PASS    = 2'd1,
        STATUS_TIMEOUT = 2'd2,
        STATUS_ERROR   = 2'd3
    } run_status_e;

    localparam int DEFAULT_RESET_HOLD     = 4;
    localparam int DEFAULT_TIMEOUT_CYCLES = 1800;

    // Error outranks timeout, which outranks pass; the flags are mutually exclusive in practice.
    function automatic run_status_e encode_status(input logic finished,
                                                  input logic timed_out,
                                                  input logic error);
        run_status_e status;
        status = STATUS_NONE;
        if (error) begin
            status = STATUS_ERROR;
        end else if (timed_out) begin
            status = STATUS_TIMEOUT;
        end else if (finished) begin
            status = STATUS_PASS;
        end
        return status;
    endfunction

endpackage

// File: rtl/kiwi_sat_counter.sv
// Saturating up-counter with synchronous clear and enable; holds at all-ones instead of wrapping.
module kiwi_sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/kiwi_run_monitor.sv
// Run controller around a KiwiC DUT: holds its reset, counts run cycles, flags done/timeout/error.
// Define KIWI_RUN_MONITOR_FINISH_EN (simulation only) to report the outcome and call $finish.
module kiwi_run_monitor
    import kiwi_run_pkg::*;
#(
    parameter int RESET_HOLD     = DEFAULT_RESET_HOLD,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int CNT_W          = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             dut_done,
    output logic             dut_reset,
    output logic             running,
    output logic             finished,
    output logic             timed_out,
    output logic             error,
    output logic [CNT_W-1:0] cycles
);

    localparam int HOLD_W = $clog2(RESET_HOLD) + 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST    = HOLD_W'(RESET_HOLD - 1);
    localparam logic [CNT_W-1:0]  TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    run_state_e state_q, state_d;
    logic dut_reset_q, dut_reset_d;
    logic running_q, running_d;
    logic finished_q, finished_d;
    logic timed_out_q, timed_out_d;
    logic error_q, error_d;

    logic              cnt_clr;
    logic              cycle_en;
    logic              hold_en;
    logic [CNT_W-1:0]  cycle_cnt;
    logic [HOLD_W-1:0] hold_cnt;

    kiwi_sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .en    (cycle_en),
        .count (cycle_cnt)
    );

    kiwi_sat_counter #(.W(HOLD_W)) u_hold_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .en    (hold_en),
        .count (hold_cnt)
    );

    always_comb begin
        state_d     = state_q;
        dut_reset_d = dut_reset_q;
        running_d   = running_q;
        finished_d  = finished_q;
        timed_out_d = timed_out_q;
        error_d     = error_q;
        cnt_clr     = 1'b0;
        cycle_en    = 1'b0;
        hold_en     = 1'b0;

        case (state_q)
            IDLE, DONE, TIMEOUT, ERROR: begin
                if (state_q == IDLE) begin
                    dut_reset_d = 1'b1;
                end
                if (start) begin
                    state_d     = HOLD;
                    cnt_clr     = 1'b1;
                    dut_reset_d = 1'b1;
                    running_d   = 1'b0;
                    finished_d  = 1'b0;
                    timed_out_d = 1'b0;
                    error_d     = 1'b0;
                end
            end
            HOLD: begin
                if (hold_cnt == HOLD_LAST) begin
                    state_d     = RUN;
                    dut_reset_d = 1'b0;
                    running_d   = 1'b1;
                end else begin
                    hold_en = 1'b1;
                end
            end
            RUN: begin
                // Cycle count is still zero only on the first RUN cycle, so done there means a stale done.
                if (dut_done) begin
                    running_d = 1'b0;
                    if (cycle_cnt == '0) begin
                        state_d     = ERROR;
                        error_d     = 1'b1;
                        dut_reset_d = 1'b1;
                    end else begin
                        state_d    = DONE;
                        finished_d = 1'b1;
                    end
                end else begin
                    cycle_en = 1'b1;
                    if ((TIMEOUT_CYCLES != 0) && (cycle_cnt == TIMEOUT_LAST)) begin
                        state_d     = TIMEOUT;
                        timed_out_d = 1'b1;
                        dut_reset_d = 1'b1;
                        running_d   = 1'b0;
                    end
                end
            end
            default: begin
                state_d     = IDLE;
                dut_reset_d = 1'b1;
                running_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            dut_reset_q <= 1'b1;
            running_q   <= 1'b0;
            finished_q  <= 1'b0;
            timed_out_q <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            dut_reset_q <= dut_reset_d;
            running_q   <= running_d;
            finished_q  <= finished_d;
            timed_out_q <= timed_out_d;
            error_q     <= error_d;
        end
    end

`ifdef KIWI_RUN_MONITOR_FINISH_EN
    logic finish_pending_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            finish_pending_q <= 1'b0;
        end else begin
            if (state_q == RUN && state_d == DONE) begin
                $display("run finished after %d cycles", cycle_cnt);
                finish_pending_q <= 1'b1;
            end else if (state_q == RUN && state_d == TIMEOUT) begin
                $display("run failed: watchdog expired after %d cycles", TIMEOUT_CYCLES);
                finish_pending_q <= 1'b1;
            end else if (state_q == RUN && state_d == ERROR) begin
                $display("run failed: done high on first run cycle");
                finish_pending_q <= 1'b1;
            end
            if (finish_pending_q) begin
                $finish;
            end
        end
    end
`endif

    assign dut_reset = dut_reset_q;
    assign running   = running_q;
    assign finished  = finished_q;
    assign timed_out = timed_out_q;
    assign error     = error_q;
    assign cycles    = cycle_cnt;

endmodule

// File: tb/tb_kiwi_run_monitor.sv
// Self-checking bench for kiwi_run_monitor: randomized runs scored against a run-level outcome model.
module tb_kiwi_run_monitor;

    localparam int HOLD = 4;
    localparam int TMO  = 1800;
    localparam int W    = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         dut_done;
    logic         dut_reset;
    logic         running;
    logic         finished;
    logic         timed_out;
    logic         error;
    logic [W-1:0] cycles;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    kiwi_run_monitor #(
        .RESET_HOLD     (HOLD),
        .TIMEOUT_CYCLES (TMO),
        .CNT_W          (W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .dut_done  (dut_done),
        .dut_reset (dut_reset),
        .running   (running),
        .finished  (finished),
        .timed_out (timed_out),
        .error     (error),
        .cycles    (cycles)
    );

    task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Outcome of a run where done first rises on RUN cycle done_at (1-based; 0 = never).
    // kind: 0 finished, 1 timed out, 2 error. run_len: RUN cycles spent with running high.
    function automatic void model_run(input int done_at, output int kind,
                                      output int exp_cycles, output int run_len);
        if (done_at == 1) begin
            kind = 2; exp_cycles = 0; run_len = 1;
        end else if (done_at != 0 && done_at <= TMO) begin
            kind = 0; exp_cycles = done_at - 1; run_len = done_at;
        end else begin
            kind = 1; exp_cycles = TMO; run_len = TMO;
        end
    endfunction

    task automatic apply_stimulus(input int done_at, input int start_at);
        int kind, exp_cycles, exp_len, hold_len, n;
        model_run(done_at, kind, exp_cycles, exp_len);

        @(negedge clk);
        start    = 1'b1;
        dut_done = (done_at == 1);
        @(negedge clk);
        start = 1'b0;
        check_output("cleared_flags", {28'd0, running, finished, timed_out, error}, 32'd0);
        check_output("cleared_cycles", cycles, 32'd0);

        hold_len = 0;
        while (dut_reset === 1'b1 && hold_len < 20) begin
            hold_len++;
            @(negedge clk);
        end
        check_output("hold_len", hold_len, HOLD);
        check_output("running_at_release", {31'd0, running}, 32'd1);

        n = 1;
        while (running === 1'b1 && n <= TMO + 20) begin
            dut_done = (done_at != 0 && n >= done_at);
            start    = (n == start_at);
            if (n == 5 && (done_at == 0 || done_at > 5)) begin
                check_output("mid_cycles", cycles, 32'(n - 1));
            end
            @(negedge clk);
            n++;
        end
        start = 1'b0;

        check_output("run_len", n - 1, exp_len);
        check_output("finished", {31'd0, finished}, {31'd0, kind == 0});
        check_output("timed_out", {31'd0, timed_out}, {31'd0, kind == 1});
        check_output("error", {31'd0, error}, {31'd0, kind == 2});
        check_output("cycles", cycles, 32'(exp_cycles));
        check_output("dut_reset_end", {31'd0, dut_reset}, {31'd0, kind != 0});

        dut_done = 1'b0;
        repeat (2) @(negedge clk);
        check_output("sticky_flags", {29'd0, finished, timed_out, error},
                     {29'd0, kind == 0, kind == 1, kind == 2});
        check_output("sticky_cycles", cycles, 32'(exp_cycles));
        check_output("sticky_running", {31'd0, running}, 32'd0);
    endtask

    initial begin
        int done_at, start_at, r;
        reset    = 1'b1;
        start    = 1'b0;
        dut_done = 1'b0;
        repeat (3) @(negedge clk);
        check_output("reset_dut_reset", {31'd0, dut_reset}, 32'd1);
        check_output("reset_flags", {28'd0, running, finished, timed_out, error}, 32'd0);
        check_output("reset_cycles", cycles, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        apply_stimulus(2, 0);
        apply_stimulus(0, 0);
        apply_stimulus(1, 0);
        apply_stimulus(TMO, 0);
        apply_stimulus(TMO + 1, 0);
        apply_stimulus(30, 12);

        // Reset pulsed on RUN cycle 11 (cycles already counted to 10).
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (HOLD) @(negedge clk);
        repeat (10) @(negedge clk);
        check_output("pre_reset_cycles", cycles, 32'd10);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_output("midrun_reset_flags", {28'd0, running, finished, timed_out, error}, 32'd0);
        check_output("midrun_reset_dut_reset", {31'd0, dut_reset}, 32'd1);
        check_output("midrun_reset_cycles", cycles, 32'd0);
        apply_stimulus(7, 0);

        for (int i = 0; i < 8; i++) begin
            r = $urandom_range(0, 9);
            if (r == 0) begin
                done_at = 0;
            end else if (r == 1) begin
                done_at = 1;
            end else begin
                done_at = $urandom_range(2, 300);
            end
            start_at = $urandom_range(0, 40);
            apply_stimulus(done_at, start_at);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
